// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Releases NDOM downstream reset domains one at a time, in index order, after
//   the system reset drops. Each released domain must report ready before the
//   next one is released. A level soft-reset request restarts the whole sequence;
//   a domain that never reports ready parks the block in a sticky fault.
//
// Parameters
//   NDOM     number of reset domains (1..8)
//   HOLD     cycles all domains stay held after reset or soft_req drops (1..256)
//   GAP      cycles between a domain going ready and the next release (1..256)
//   TIMEOUT  max cycles to wait for rdy[idx]; 0 disables the timeout (0..256)
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   soft_req  synchronous level soft-reset request, active-high
//   rdy       per-domain ready, meaningful once that domain's reset is released
//   dom_rst   per-domain reset, active-high, registered
//   busy      high in every state except RUN
//   err       sticky timeout flag, cleared only by rst or soft_req
//   err_idx   index of the domain that timed out, valid while err is high

module reset_sequencer #(
  parameter int unsigned NDOM    = 4,
  parameter int unsigned HOLD    = 16,
  parameter int unsigned GAP     = 8,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            soft_req,
  input  logic [NDOM-1:0] rdy,
  output logic [NDOM-1:0] dom_rst,
  output logic            busy,
  output logic            err,
  output logic [2:0]      err_idx
);

  // Terminal counts: a parameter value N makes a counting state last N edges.
  localparam logic [7:0] HoldLast = 8'(HOLD - 1);
  localparam logic [7:0] GapLast  = 8'(GAP - 1);
  localparam logic [7:0] ToLast   = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [2:0] IdxLast  = 3'(NDOM - 1);
  localparam bit         ToEn     = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    StHold,
    StGap,
    StWait,
    StRun,
    StFault
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [NDOM-1:0] dom_rst_q, dom_rst_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [2:0]      err_idx_q, err_idx_d;

  // Zero-padded to 8 bits so a 3-bit index always selects a defined bit.
  logic [7:0]      rdy_ext;
  logic            rdy_cur;
  logic [NDOM-1:0] rel_mask;

  assign rdy_ext  = 8'(rdy);
  assign rdy_cur  = rdy_ext[idx_q];
  assign rel_mask = (NDOM)'(1) << idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StHold;
      cnt_q     <= 8'd0;
      idx_q     <= 3'd0;
      dom_rst_q <= '1;
      busy_q    <= 1'b1;
      err_q     <= 1'b0;
      err_idx_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dom_rst_q <= dom_rst_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dom_rst_d = dom_rst_q;
    busy_d    = busy_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;

    if (soft_req) begin
      // Overrides everything; HOLD counting only starts once soft_req drops.
      state_d   = StHold;
      cnt_d     = 8'd0;
      idx_d     = 3'd0;
      dom_rst_d = '1;
      busy_d    = 1'b1;
      err_d     = 1'b0;
    end else begin
      unique case (state_q)
        StHold: begin
          dom_rst_d = '1;
          busy_d    = 1'b1;
          if (cnt_q == HoldLast) begin
            cnt_d   = 8'd0;
            idx_d   = 3'd0;
            state_d = StGap;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        StGap: begin
          if (cnt_q == GapLast) begin
            dom_rst_d = dom_rst_q & ~rel_mask;
            cnt_d     = 8'd0;
            state_d   = StWait;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        StWait: begin
          // Ready is checked first so it wins over an expiring timeout.
          if (rdy_cur) begin
            if (idx_q == IdxLast) begin
              state_d = StRun;
              busy_d  = 1'b0;
            end else begin
              idx_d   = idx_q + 3'd1;
              cnt_d   = 8'd0;
              state_d = StGap;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
            if (ToEn && (cnt_q == ToLast)) begin
              err_d     = 1'b1;
              err_idx_d = idx_q;
              dom_rst_d = '1;
              state_d   = StFault;
            end
          end
        end

        StRun: begin
          dom_rst_d = '0;
          busy_d    = 1'b0;
        end

        StFault: begin
          dom_rst_d = '1;
          busy_d    = 1'b1;
        end

        default: begin
          state_d   = StHold;
          cnt_d     = 8'd0;
          idx_d     = 3'd0;
          dom_rst_d = '1;
          busy_d    = 1'b1;
        end
      endcase
    end
  end

  assign dom_rst = dom_rst_q;
  assign busy    = busy_q;
  assign err     = err_q;
  assign err_idx = err_idx_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios followed by a randomized phase,
// every edge compared against an event-time reference model.

module tb_reset_sequencer;

  localparam int unsigned NDOM    = 4;
  localparam int unsigned HOLD    = 16;
  localparam int unsigned GAP     = 8;
  localparam int unsigned TIMEOUT = 32;

  logic       clk;
  logic       rst;
  logic       soft_req;
  logic [3:0] rdy;
  logic [3:0] dom_rst;
  logic       busy;
  logic       err;
  logic [2:0] err_idx;

  // Second instance with the timeout disabled.
  logic       rst2;
  logic [3:0] rdy2;
  logic       soft2;
  logic [3:0] dom_rst2;
  logic       busy2;
  logic       err2;
  logic [2:0] err_idx2;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  reset_sequencer #(
    .NDOM   (NDOM),
    .HOLD   (HOLD),
    .GAP    (GAP),
    .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .soft_req(soft_req),
    .rdy     (rdy),
    .dom_rst (dom_rst),
    .busy    (busy),
    .err     (err),
    .err_idx (err_idx)
  );

  reset_sequencer #(
    .NDOM   (NDOM),
    .HOLD   (HOLD),
    .GAP    (GAP),
    .TIMEOUT(0)
  ) u_dut_to0 (
    .clk     (clk),
    .rst     (rst2),
    .soft_req(soft2),
    .rdy     (rdy2),
    .dom_rst (dom_rst2),
    .busy    (busy2),
    .err     (err2),
    .err_idx (err_idx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, kept as absolute edge times rather than counters:
  //   m_nrel    domains released so far (always a low-index prefix)
  //   m_rel_at  edge at which the next release is due
  //   m_wait_from edge of the most recent release (start of its ready wait)
  int   m_now;
  int   m_nrel;
  int   m_rel_at;
  int   m_wait_from;
  bit   m_waiting;
  bit   m_done;
  bit   m_fault;
  bit   m_err;
  logic [2:0] m_eidx;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_nrel    = 0;
    m_waiting = 0;
    m_done    = 0;
    m_fault   = 0;
    m_err     = 0;
    m_eidx    = 3'd0;
    m_rel_at  = m_now + int'(HOLD) + int'(GAP);
  endtask

  task automatic model_edge(input logic s, input logic [3:0] r);
    int k;
    m_now++;
    if (s) begin
      m_nrel    = 0;
      m_waiting = 0;
      m_done    = 0;
      m_fault   = 0;
      m_err     = 0;
      m_rel_at  = m_now + int'(HOLD) + int'(GAP);
    end else if (m_fault || m_done) begin
      // parked until soft_req or rst
    end else if (m_waiting) begin
      k = m_nrel - 1;
      if (r[k[1:0]]) begin
        if (m_nrel == int'(NDOM)) begin
          m_done = 1;
        end else begin
          m_waiting = 0;
          m_rel_at  = m_now + int'(GAP);
        end
      end else if (TIMEOUT != 0 && (m_now - m_wait_from) == int'(TIMEOUT)) begin
        m_fault   = 1;
        m_err     = 1;
        m_eidx    = 3'(k);
        m_nrel    = 0;
        m_waiting = 0;
      end
    end else if (m_now == m_rel_at) begin
      m_nrel++;
      m_waiting   = 1;
      m_wait_from = m_now;
    end
  endtask

  task automatic compare_model();
    logic [3:0] e_dom;
    e_dom = m_fault ? 4'hF : 4'(4'hF << m_nrel);
    check("dom_rst", 8'(dom_rst), 8'(e_dom));
    check("busy", 8'(busy), 8'(!m_done));
    check("err", 8'(err), 8'(m_err));
    if (m_err) check("err_idx", 8'(err_idx), 8'(m_eidx));
  endtask

  // Drive inputs for the coming edge, take the edge, then compare 1 ns later.
  task automatic step(input logic s, input logic [3:0] r);
    soft_req = s;
    rdy      = r;
    @(posedge clk);
    model_edge(s, r);
    #1;
    compare_model();
  endtask

  // Raise rst between edges and check the outputs before any edge arrives.
  task automatic do_reset();
    #3;
    rst      = 1'b1;
    soft_req = 1'b0;
    #1;
    check("async_dom_rst", 8'(dom_rst), 8'h0F);
    check("async_busy", 8'(busy), 8'h01);
    check("async_err", 8'(err), 8'h00);
    check("async_err_idx", 8'(err_idx), 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int pden;
    int soft_left;
    logic [3:0] r;

    rst      = 1'b0;
    rst2     = 1'b0;
    soft_req = 1'b0;
    soft2    = 1'b0;
    rdy      = 4'h0;
    rdy2     = 4'h0;
    m_now    = 0;
    #1;
    rst2 = 1'b1;
    do_reset();
    rst2 = 1'b0;

    // Release timing with every domain ready at once.
    for (int e = 1; e <= 60; e++) begin
      step(1'b0, 4'hF);
      if (e == 23) check("t1_pre_rel0", 8'(dom_rst), 8'h0F);
      if (e == 24) check("t1_rel0", 8'(dom_rst), 8'h0E);
      if (e == 33) check("t1_rel1", 8'(dom_rst), 8'h0C);
      if (e == 42) check("t1_rel2", 8'(dom_rst), 8'h08);
      if (e == 51) check("t1_rel3", 8'(dom_rst), 8'h00);
      if (e == 51) check("t1_busy_51", 8'(busy), 8'h01);
      if (e == 52) check("t1_busy_52", 8'(busy), 8'h00);
      if (e == 52) check("t1_err", 8'(err), 8'h00);
    end

    // Domain 1 slow to report ready: driven high after edge 38, first sampled at 39.
    step(1'b1, 4'hF);
    for (int e = 1; e <= 60; e++) begin
      step(1'b0, (e >= 39) ? 4'hF : 4'b1101);
      if (e == 46) check("t2_hold2", 8'(dom_rst), 8'h0C);
      if (e == 47) check("t2_rel2", 8'(dom_rst), 8'h08);
      if (e == 60) check("t2_err", 8'(err), 8'h00);
    end

    // soft_req held three cycles while running.
    for (int e = 1; e <= 3; e++) begin
      step(1'b1, 4'hF);
      if (e == 1) check("t4_dom_rst", 8'(dom_rst), 8'h0F);
      if (e == 1) check("t4_busy", 8'(busy), 8'h01);
    end
    for (int e = 1; e <= 60; e++) begin
      step(1'b0, 4'hF);
      if (e == 23) check("t4_pre_rel0", 8'(dom_rst), 8'h0F);
      if (e == 24) check("t4_rel0", 8'(dom_rst), 8'h0E);
      if (e == 52) check("t4_run", 8'(busy), 8'h00);
    end

    // Domain 2 never ready: timeout fault, held, then cleared by soft_req.
    step(1'b1, 4'b1011);
    for (int e = 1; e <= 180; e++) begin
      step(1'b0, 4'b1011);
      if (e == 73) check("t3_pre_err", 8'(err), 8'h00);
      if (e == 73) check("t3_pre_dom", 8'(dom_rst), 8'h08);
      if (e == 74) check("t3_err", 8'(err), 8'h01);
      if (e == 74) check("t3_err_idx", 8'(err_idx), 8'h02);
      if (e == 74) check("t3_dom_rst", 8'(dom_rst), 8'h0F);
      if (e == 74) check("t3_busy", 8'(busy), 8'h01);
      if (e == 180) check("t3_err_held", 8'(err), 8'h01);
      if (e == 180) check("t3_dom_held", 8'(dom_rst), 8'h0F);
    end
    step(1'b1, 4'b1011);
    check("t3_err_clr", 8'(err), 8'h00);

    // Asynchronous reset during the gap before domain 2.
    for (int e = 1; e <= 37; e++) begin
      step(1'b0, 4'hF);
      if (e == 37) check("t5_mid_gap", 8'(dom_rst), 8'h0C);
    end
    do_reset();
    for (int e = 1; e <= 60; e++) begin
      step(1'b0, 4'hF);
      if (e == 24) check("t5_rel0", 8'(dom_rst), 8'h0E);
      if (e == 51) check("t5_rel3", 8'(dom_rst), 8'h00);
      if (e == 52) check("t5_busy", 8'(busy), 8'h00);
    end

    // Ready arriving on the very edge the timeout would expire.
    do_reset();
    for (int e = 1; e <= 70; e++) begin
      step(1'b0, (e >= 56) ? 4'hF : 4'h0);
      if (e == 55) check("t6_wait", 8'(dom_rst), 8'h0E);
      if (e == 56) check("t6_no_err", 8'(err), 8'h00);
      if (e == 56) check("t6_busy", 8'(busy), 8'h01);
      if (e == 64) check("t6_rel1", 8'(dom_rst), 8'h0C);
    end

    // Randomized phase: ready probability varies per segment, occasional
    // soft requests of random length and occasional async resets.
    pden      = 8;
    soft_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       pden = 2;
          1:       pden = 8;
          default: pden = 40;
        endcase
      end
      if ($urandom_range(0, 1499) == 0) do_reset();
      if (soft_left == 0 && $urandom_range(0, 249) == 0) soft_left = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, pden - 1) == 0);
      step(soft_left != 0, r);
      if (soft_left != 0) soft_left--;
    end

    // Timeout disabled: domain 0 released, waits indefinitely without error.
    check("to0_dom_rst", 8'(dom_rst2), 8'h0E);
    check("to0_busy", 8'(busy2), 8'h01);
    check("to0_err", 8'(err2), 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
